prog_seq_detector: RTL and testbench
====================================

PROG_SEQ_DETECTOR -- requirements
Module: prog_seq_detector

Interface
REQ-001 Parameter MAX_LEN, default 8, sets the maximum pattern length in bits (2..32).
REQ-002 Parameter CNT_W, default 16, sets the match counter width.
REQ-003 Derived constant LEN_W = $clog2(MAX_LEN+1) SHALL set the length field width.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 cfg_we  input  1  load cfg_pattern, cfg_len and cfg_overlap this cycle.
REQ-007 cfg_pattern  input  MAX_LEN  pattern; bit cfg_len-1 is the oldest bit and bit 0 is the newest.
REQ-008 cfg_len  input  LEN_W  active pattern length.
REQ-009 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 in_valid  input  1  ain qualifier.
REQ-011 ain  input  1  serial data bit.
REQ-012 match  output  1  Mealy detect pulse.
REQ-013 match_cnt  output  CNT_W  saturating match count; exists only with SEQDET_CNT_EN.

Function
REQ-014 The block SHALL hold registered pattern, length and overlap values, a MAX_LEN-1 bit history shift register and a fill counter of width LEN_W.
REQ-015 On in_valid=1 and cfg_we=0, the block SHALL shift ain into history bit 0 and increment fill, saturating at MAX_LEN-1.
REQ-016 match SHALL be combinational: match = in_valid & ~cfg_we & (len!=0) & (fill >= len-1) & ({history,ain} low len bits == pattern low len bits).
REQ-017 The block SHALL have zero latency: match is asserted in the same cycle as the final pattern bit.
REQ-018 Bits presented with in_valid=0 SHALL be ignored; history and fill hold, and match=0.
REQ-019 Overlap mode: after a match, history and fill SHALL be retained, so a suffix of the match can start the next match.
REQ-020 Non-overlap mode: on a match, fill SHALL clear to 0 so the next match needs len fresh bits.
REQ-021 cfg_we=1 SHALL load the configuration and clear history and fill; ain is ignored in that cycle.
REQ-022 A cfg_len value above MAX_LEN SHALL be stored as MAX_LEN.
REQ-023 cfg_len=0 SHALL disable detection: match stays 0 while history still shifts.
REQ-024 A cfg_len of 1 SHALL match every valid bit equal to pattern bit 0.

Reset
REQ-025 Asserting reset SHALL clear history, fill, pattern, len (which disables detection), overlap and match_cnt to 0.
REQ-026 With len=0 after reset, match SHALL be 0 while reset is asserted and afterwards until configuration is loaded.
REQ-027 Reset asserted mid-stream SHALL discard all partial-match progress, and configuration SHALL be reloaded before the block is used again.

Configuration
REQ-028 Macro SEQDET_CNT_EN defined: the match_cnt port exists, increments on each match cycle, saturates at all-ones, and clears on reset and on cfg_we.
REQ-029 Macro SEQDET_CNT_EN undefined: the match_cnt port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package seqdet_pkg SHALL hold the MODE_OVERLAP/MODE_NONOVERLAP constants and the MAX_LEN limit constant (32).
REQ-031 Sub-module seqdet_sat_counter (parameter W; inputs clk, reset, clr, inc; output cnt) SHALL implement the saturating counter and be instantiated only under SEQDET_CNT_EN.
REQ-032 The history/compare path SHALL remain in the top module with no further sub-modules.

Verification
REQ-033 Load pattern 4'b1011, len 4, overlap 1; stream 1,0,1,1,0,1,1 with in_valid=1 -> match high on bits 4 and 7; match_cnt=2.
REQ-034 Same stream with overlap 0 -> match high only on bit 4; match_cnt=1.
REQ-035 Pattern 1011 with in_valid low for 3 cycles between bits 2 and 3 -> match still on the 4th valid bit; match=0 during the gap cycles.
REQ-036 cfg_we pulsed after 3 valid bits of 1011, then 1,1 -> no match until 4 new valid bits 1,0,1,1 are received.
REQ-037 reset asserted mid-pattern, then pattern reloaded -> no match from pre-reset bits; match_cnt=0.
REQ-038 CNT_W=2, pattern 1'b1, len 1, five 1-bits -> match_cnt saturates at 3; cfg_len=12 with MAX_LEN=8 -> len reads 8.

Source files
------------

// File: rtl/seqdet_pkg.sv
// Shared constants for the programmable sequence detector.
// The overlap mode encoding matches the cfg_overlap input bit.
package seqdet_pkg;

   typedef enum logic {
      MODE_NONOVERLAP = 1'b0,
      MODE_OVERLAP    = 1'b1
   } mode_e;

   localparam int SEQDET_MAX_LEN_LIMIT = 32;

endpackage

// File: rtl/seqdet_sat_counter.sv
// Saturating up-counter that holds at all-ones and clears on reset or clr.
module seqdet_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   // clr takes priority over inc, so a config reload in a match cycle still leaves zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/prog_seq_detector.sv
// Programmable serial sequence detector with a zero-latency Mealy match output.
// Define SEQDET_CNT_EN to add the saturating match_cnt output.
module prog_seq_detector
   import seqdet_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 16,
   localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               in_valid,
   input  logic               ain,
`ifdef SEQDET_CNT_EN
   output logic [CNT_W-1:0]   match_cnt,
`endif
   output logic               match
);

   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

   logic [MAX_LEN-1:0] pattern;
   logic [LEN_W-1:0]   len;
   mode_e              overlap;
   logic [MAX_LEN-2:0] history;
   logic [LEN_W-1:0]   fill;
   logic [MAX_LEN-1:0] window;
   logic [MAX_LEN-1:0] mask;

   // The current bit joins the history so the final pattern bit matches in its own cycle.
   assign window = {history, ain};

   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < int'(len));
      end
   end

   assign match = in_valid && !cfg_we && (len != '0) && (fill >= (len - LEN_ONE))
                  && (((window ^ pattern) & mask) == '0);

   // Non-overlap mode restarts fill on a match so the next hit needs len fresh bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pattern <= '0;
         len     <= '0;
         overlap <= MODE_NONOVERLAP;
         history <= '0;
         fill    <= '0;
      end else if (cfg_we) begin
         pattern <= cfg_pattern;
         len     <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
         overlap <= mode_e'(cfg_overlap);
         history <= '0;
         fill    <= '0;
      end else if (in_valid) begin
         history <= window[MAX_LEN-2:0];
         if (match && (overlap == MODE_NONOVERLAP)) begin
            fill <= '0;
         end else if (fill < FILL_MAX) begin
            fill <= fill + LEN_ONE;
         end
      end
   end

`ifdef SEQDET_CNT_EN
   seqdet_sat_counter #(
      .W(CNT_W)
   ) u_match_cnt (
      .clk  (clk),
      .reset(reset),
      .clr  (cfg_we),
      .inc  (match),
      .cnt  (match_cnt)
   );
`endif

endmodule

// File: tb/tb_prog_seq_detector.sv
// Table-driven bench for prog_seq_detector, plus hand sequences for reset and saturation.
// Counter checks are included when SEQDET_CNT_EN is defined.
module tb_prog_seq_detector;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);

   typedef struct {
      string              name;
      logic               we;
      logic [MAX_LEN-1:0] pat;
      logic [LEN_W-1:0]   len;
      logic               ovl;
      logic               valid;
      logic               ain;
      logic               expMatch;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic cfgWe, cfgOverlap, inValid, ain, match;
   logic [MAX_LEN-1:0] cfgPattern;
   logic [LEN_W-1:0]   cfgLen;
   logic sWe, sOverlap, sValid, sAin, sMatch;
   logic [MAX_LEN-1:0] sPattern;
   logic [LEN_W-1:0]   sLen;
`ifdef SEQDET_CNT_EN
   logic [15:0] matchCnt;
   logic [1:0]  sMatchCnt;
   int          expCnt;
`endif

   int   checkCount = 0;
   int   passCount  = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   prog_seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfgWe), .cfg_pattern(cfgPattern),
      .cfg_len(cfgLen), .cfg_overlap(cfgOverlap), .in_valid(inValid), .ain(ain),
`ifdef SEQDET_CNT_EN
      .match_cnt(matchCnt),
`endif
      .match(match)
   );

   prog_seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dutSmall (
      .clk(clk), .reset(reset), .cfg_we(sWe), .cfg_pattern(sPattern),
      .cfg_len(sLen), .cfg_overlap(sOverlap), .in_valid(sValid), .ain(sAin),
`ifdef SEQDET_CNT_EN
      .match_cnt(sMatchCnt),
`endif
      .match(sMatch)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      cfgWe      = v.we;
      cfgPattern = v.pat;
      cfgLen     = v.len;
      cfgOverlap = v.ovl;
      inValid    = v.valid;
      ain        = v.ain;
   endtask

   task automatic addCfg(input string n, input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                         input logic o);
      vecs.push_back('{n, 1'b1, p, l, o, 1'b0, 1'b1, 1'b0});
   endtask

   // Bits: '0'/'1' are valid bits, 'x' is an idle cycle; exps gives the expected match per cycle.
   task automatic addStream(input string n, input string bits, input string exps);
      for (int i = 0; i < bits.len(); i++) begin
         vecs.push_back('{n, 1'b0, '0, '0, 1'b0, bits[i] != "x", bits[i] != "0", exps[i] == "1"});
      end
   endtask

   initial begin
      reset = 1'b1;
      cfgWe = 1'b0; cfgPattern = '0; cfgLen = '0; cfgOverlap = 1'b0; inValid = 1'b1; ain = 1'b1;
      sWe = 1'b0; sPattern = '0; sLen = '0; sOverlap = 1'b0; sValid = 1'b0; sAin = 1'b0;
      #1;
      checkOutput("match during reset", match, 0);
`ifdef SEQDET_CNT_EN
      checkOutput("cnt during reset", matchCnt, 0);
      expCnt = 0;
`endif
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("match after reset, unconfigured", match, 0);

      addStream("unconfigured", "1010", "0000");
      addCfg("ovl cfg", 8'b1011, 4, 1'b1);
      addStream("ovl stream", "1011011", "0001001");
      addCfg("nonovl cfg", 8'b1011, 4, 1'b0);
      addStream("nonovl stream", "1011011", "0001000");
      addCfg("gap cfg", 8'b1011, 4, 1'b1);
      addStream("gap stream", "10xxx11", "0000001");
      addCfg("reload cfg", 8'b1011, 4, 1'b1);
      addStream("pre-reload", "101", "000");
      addCfg("reload mid", 8'b1011, 4, 1'b1);
      addStream("post-reload", "11011", "00001");
      addCfg("len1 cfg", 8'b0000_0001, 1, 1'b0);
      addStream("len1 stream", "1011x1", "101101");
      addCfg("len0 cfg", 8'b0000_0000, 0, 1'b1);
      addStream("len0 stream", "00000000", "00000000");
      addCfg("clamp cfg", 8'hA5, 12, 1'b1);
      addStream("clamp stream", "1010010110100101", "0000000100000001");

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("%s #%0d match", vecs[i].name, i), match, vecs[i].expMatch);
`ifdef SEQDET_CNT_EN
         checkOutput($sformatf("%s #%0d cnt", vecs[i].name, i), matchCnt, expCnt);
         if (vecs[i].we) expCnt = 0;
         else if (vecs[i].expMatch) expCnt++;
`endif
      end

      // Reset mid-pattern must wipe partial progress and the configuration.
      addCfg("rst cfg", 8'b1011, 4, 1'b1);
      applyStimulus(vecs[$]);
      for (int i = 0; i < 3; i++) begin
         applyStimulus('{"rst", 1'b0, '0, '0, 1'b0, 1'b1, (i != 1), 1'b0});
      end
      @(negedge clk);
      inValid = 1'b1; ain = 1'b1; reset = 1'b1;
      #1;
      checkOutput("mid-stream reset match", match, 0);
`ifdef SEQDET_CNT_EN
      checkOutput("mid-stream reset cnt", matchCnt, 0);
`endif
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("post-reset len0 match", match, 0);
      applyStimulus('{"rst", 1'b1, 8'b1011, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0});
      applyStimulus('{"rst", 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0});
      #1;
      checkOutput("post-reset first bit", match, 0);
      applyStimulus('{"rst", 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0});
      applyStimulus('{"rst", 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0});
      #1;
      checkOutput("post-reset third bit", match, 0);
      applyStimulus('{"rst", 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0});
      #1;
      checkOutput("post-reset fresh match", match, 1);
`ifdef SEQDET_CNT_EN
      checkOutput("post-reset cnt before match", matchCnt, 0);
`endif
      @(negedge clk);
      inValid = 1'b0;

      // Two-bit counter must stop at 3 after five single-bit matches.
      sWe = 1'b1; sPattern = 8'b0000_0001; sLen = 4'd1; sOverlap = 1'b1; sValid = 1'b0; sAin = 1'b1;
      @(negedge clk);
      sWe = 1'b0; sValid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput($sformatf("sat match #%0d", i), sMatch, 1);
         @(negedge clk);
      end
      sValid = 1'b0;
      #1;
      checkOutput("sat idle match", sMatch, 0);
`ifdef SEQDET_CNT_EN
      checkOutput("sat cnt", sMatchCnt, 3);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
